// File: rtl/array_util_pkg.sv
// Shared definitions for the array loader and the byte-dump serializer:
// state encoding plus array-size and index-width derivations.
package array_util;

  typedef enum logic {
    StReceiving = 1'b0,
    StSending   = 1'b1
  } array_state_e;

  // Number of whole bytes needed to carry an array of total_bits bits.
  function automatic int unsigned array_size(input int unsigned total_bits);
    return total_bits / 8;
  endfunction

  // Index must be able to represent 0..size inclusive.
  function automatic int unsigned index_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/array_load.sv
// Assembles a byte stream into an ARRAY_HEIGHT x ARRAY_WIDTH x CELL_WIDTH array.
// Optional in_last frame-length checking is enabled by defining ARRAY_LOAD_LAST_CHECK_EN.
module array_load
  import array_util::*;
#(
  parameter int unsigned ARRAY_HEIGHT = 16,
  parameter int unsigned ARRAY_WIDTH  = 3,
  parameter int unsigned CELL_WIDTH   = 8
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [7:0]                                  in_data,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic                                        in_last,
  output logic [ARRAY_HEIGHT*ARRAY_WIDTH*CELL_WIDTH-1:0] out_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        out_error
);

  localparam int unsigned DataWidth = ARRAY_HEIGHT * ARRAY_WIDTH * CELL_WIDTH;
  localparam int unsigned ArraySize = array_size(DataWidth);
  localparam int unsigned IdxWidth  = index_width(ArraySize);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(ArraySize - 1);

  array_state_e         state_q, state_d;
  logic [IdxWidth-1:0]  index_q, index_d;
  logic [DataWidth-1:0] buffer_q, buffer_d;
  logic                 error_q, error_d;

`ifndef ARRAY_LOAD_LAST_CHECK_EN
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    buffer_d = buffer_q;
    error_d  = error_q;
    unique case (state_q)
      StReceiving: begin
        if (in_valid) begin
          for (int k = 0; k < ArraySize; k++) begin
            if (index_q == IdxWidth'(k)) buffer_d[8*k +: 8] = in_data;
          end
`ifdef ARRAY_LOAD_LAST_CHECK_EN
          if (index_q == LastIdx) begin
            state_d = StSending;
            error_d = !in_last;
          end else if (in_last) begin
            // Short frame: unwritten bytes stay zero.
            state_d = StSending;
            error_d = 1'b1;
          end else begin
            index_d = index_q + 1'b1;
          end
`else
          if (index_q == LastIdx) state_d = StSending;
          else                    index_d = index_q + 1'b1;
`endif
        end
      end
      StSending: begin
        if (out_ready) begin
          state_d  = StReceiving;
          index_d  = '0;
          buffer_d = '0;
          error_d  = 1'b0;
        end
      end
      default: state_d = StReceiving;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StReceiving;
      index_q  <= '0;
      buffer_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      buffer_q <= buffer_d;
      error_q  <= error_d;
    end
  end

  assign in_ready  = (state_q == StReceiving);
  assign out_valid = (state_q == StSending);
  assign out_data  = buffer_q;
  assign out_error = error_q;

endmodule

// File: tb/tb_array_load.sv
// Bench for array_load: a 2x2x8 instance (index 0) and a default 16x3x8 instance (index 1),
// checked every cycle against a frame-level byte model plus literal expectations.
module tb_array_load;

`ifdef ARRAY_LOAD_LAST_CHECK_EN
  localparam bit LastChk = 1'b1;
`else
  localparam bit LastChk = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   in_data [2];
  logic         in_valid[2];
  logic         in_last [2];
  logic         out_ready[2];
  logic         s_in_ready, s_out_valid, s_out_error;
  logic         b_in_ready, b_out_valid, b_out_error;
  logic [31:0]  s_out_data;
  logic [383:0] b_out_data;
  logic [383:0] od[2];
  logic         rdy[2], ov[2], oe[2];

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  always #5 clock = ~clock;

  array_load #(.ARRAY_HEIGHT(2), .ARRAY_WIDTH(2), .CELL_WIDTH(8)) u_small (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data[0]),
    .in_valid (in_valid[0]),
    .in_ready (s_in_ready),
    .in_last  (in_last[0]),
    .out_data (s_out_data),
    .out_valid(s_out_valid),
    .out_ready(out_ready[0]),
    .out_error(s_out_error)
  );

  array_load u_big (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data[1]),
    .in_valid (in_valid[1]),
    .in_ready (b_in_ready),
    .in_last  (in_last[1]),
    .out_data (b_out_data),
    .out_valid(b_out_valid),
    .out_ready(out_ready[1]),
    .out_error(b_out_error)
  );

  assign od[0]  = {352'b0, s_out_data};
  assign od[1]  = b_out_data;
  assign rdy[0] = s_in_ready;
  assign rdy[1] = b_in_ready;
  assign ov[0]  = s_out_valid;
  assign ov[1]  = b_out_valid;
  assign oe[0]  = s_out_error;
  assign oe[1]  = b_out_error;

  // Frame-level model: a list of received bytes and a "frame complete" flag.
  int         sz[2] = '{4, 48};
  logic [7:0] mb[2][48];
  int         mc[2];
  bit         ms[2];
  bit         me[2];

  always @(posedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (reset || (ms[u] && out_ready[u])) begin
        ms[u] = 1'b0;
        mc[u] = 0;
        me[u] = 1'b0;
        for (int k = 0; k < 48; k++) mb[u][k] = 8'h00;
      end else if (!ms[u] && in_valid[u]) begin
        mb[u][mc[u]] = in_data[u];
        mc[u]++;
        if (mc[u] == sz[u]) begin
          ms[u] = 1'b1;
          me[u] = LastChk && !in_last[u];
        end else if (LastChk && in_last[u]) begin
          ms[u] = 1'b1;
          me[u] = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      for (int u = 0; u < 2; u++) begin
        logic [383:0] exp_d;
        exp_d = '0;
        for (int k = 0; k < sz[u]; k++) exp_d[8*k +: 8] = mb[u][k];
        check($sformatf("model_in_ready[%0d]", u), 384'(rdy[u]), 384'(!ms[u]));
        check($sformatf("model_out_valid[%0d]", u), 384'(ov[u]), 384'(ms[u]));
        if (ms[u]) begin
          check($sformatf("model_out_data[%0d]", u), od[u], exp_d);
          check($sformatf("model_out_error[%0d]", u), 384'(oe[u]), 384'(me[u]));
        end
      end
    end
  end

  // Inputs change 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input int u, input logic [7:0] d, input logic last);
    bit acc;
    in_data[u]  = d;
    in_last[u]  = last;
    in_valid[u] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = rdy[u];
      tick();
      if (acc) begin
        in_valid[u] = 1'b0;
        in_last[u]  = 1'b0;
        return;
      end
    end
    in_valid[u] = 1'b0;
    in_last[u]  = 1'b0;
    check("send_timeout", 384'(0), 384'(1));
  endtask

  task automatic wait_valid(input int u);
    for (int i = 0; i < 100; i++) begin
      if (ov[u]) return;
      tick();
    end
    check("valid_timeout", 384'(0), 384'(1));
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      in_data[u]   = 8'h00;
      in_valid[u]  = 1'b0;
      in_last[u]   = 1'b0;
      out_ready[u] = 1'b1;
    end
    repeat (3) tick();
    check("reset_in_ready", 384'(s_in_ready), 384'(1));
    check("reset_out_valid", 384'(s_out_valid), 384'(0));
    check("reset_out_data", od[1], 384'(0));
    check("reset_out_error", 384'(b_out_error), 384'(0));
    reset    = 1'b0;
    check_en = 1'b1;
    tick();

    // Back-to-back frame, consumer always ready.
    send_byte(0, 8'h11, 1'b0);
    send_byte(0, 8'h22, 1'b0);
    send_byte(0, 8'h33, 1'b0);
    send_byte(0, 8'h44, 1'b0);
    check("req031_valid", 384'(s_out_valid), 384'(1));
    check("req031_data", od[0], 384'h44332211);
    tick();
    check("req031_release", 384'(s_in_ready), 384'(1));

    // Consumer stalls; extra bytes offered while sending must be ignored.
    out_ready[0] = 1'b0;
    send_byte(0, 8'h55, 1'b0);
    send_byte(0, 8'h66, 1'b0);
    send_byte(0, 8'h77, 1'b0);
    send_byte(0, 8'h88, 1'b0);
    in_data[0]  = 8'hEE;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("req032_hold", od[0], 384'h88776655);
      check("req032_in_ready", 384'(s_in_ready), 384'(0));
    end
    out_ready[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    check("req032_in_ready_after", 384'(s_in_ready), 384'(1));
    check("req032_data_cleared", od[0], 384'(0));

    // Reset mid-frame drops the partial array.
    send_byte(0, 8'h9A, 1'b0);
    send_byte(0, 8'hBC, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("req035_no_valid", 384'(s_out_valid), 384'(0));
      tick();
    end
    send_byte(0, 8'h01, 1'b0);
    send_byte(0, 8'h02, 1'b0);
    send_byte(0, 8'h03, 1'b0);
    send_byte(0, 8'h04, 1'b0);
    wait_valid(0);
    check("req035_data", od[0], 384'h04030201);
    tick();

`ifdef ARRAY_LOAD_LAST_CHECK_EN
    send_byte(0, 8'hAA, 1'b0);
    send_byte(0, 8'hBB, 1'b1);
    check("req033_data", od[0], 384'h0000BBAA);
    check("req033_error", 384'(s_out_error), 384'(1));
    tick();
    for (int k = 0; k < 4; k++) send_byte(0, 8'(k + 1), 1'b0);
    check("req034_no_last_error", 384'(s_out_error), 384'(1));
    tick();
    for (int k = 0; k < 4; k++) send_byte(0, 8'(k + 1), k == 3);
    check("req034_last_error", 384'(s_out_error), 384'(0));
    check("req034_data", od[0], 384'h04030201);
    tick();
`endif

    // Default geometry: two 48-byte frames with idle gaps, byte k = k.
    for (int f = 0; f < 2; f++) begin
      bit ok;
      for (int k = 0; k < 48; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_byte(1, 8'(k), 1'b0);
      end
      wait_valid(1);
      ok = 1'b1;
      for (int k = 0; k < 48; k++) if (od[1][8*k +: 8] !== 8'(k)) ok = 1'b0;
      check($sformatf("req036_frame%0d", f), 384'(ok), 384'(1));
      tick();
    end

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/array_load.md
ARRAY_LOAD -- requirements
Module: array_load

Interface
REQ-001 Parameter ARRAY_HEIGHT, default 16, number of array rows.
REQ-002 Parameter ARRAY_WIDTH, default 3, number of cells per row.
REQ-003 Parameter CELL_WIDTH, default 8, bits per cell; ARRAY_HEIGHT*ARRAY_WIDTH*CELL_WIDTH SHALL be a multiple of 8.
REQ-004 clock  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  8  byte stream payload.
REQ-007 in_valid  input  1  byte offered.
REQ-008 in_ready  output  1  module accepts a byte this cycle.
REQ-009 in_last  input  1  marks final byte of a frame.
REQ-010 out_data  output  ARRAY_HEIGHT*ARRAY_WIDTH*CELL_WIDTH  assembled array.
REQ-011 out_valid  output  1  assembled array available.
REQ-012 out_ready  input  1  consumer accepts array.
REQ-013 out_error  output  1  frame length mismatch flag, qualified by out_valid.

Function
REQ-014 ARRAY_SIZE = total bits / 8; byte index counter SHALL be $clog2(ARRAY_SIZE+1) bits wide.
REQ-015 Two states: RECEIVING (in_ready=1, out_valid=0) and SENDING (in_ready=0, out_valid=1).
REQ-016 Byte accepted on in_valid && in_ready; byte k SHALL be written to out_data bits [8k+7:8k], k counting from 0.
REQ-017 Index SHALL increment by 1 per accepted byte; bytes not yet written SHALL read as 0 in the buffer.
REQ-018 Acceptance of byte ARRAY_SIZE-1 SHALL move to SENDING; out_valid SHALL assert the following cycle (1-cycle latency).
REQ-019 out_data and out_error SHALL remain stable while out_valid && !out_ready.
REQ-020 out_valid && out_ready SHALL return to RECEIVING next cycle, with index cleared and buffer zeroed; no byte accepted in that handshake cycle.
REQ-021 in_valid asserted during SENDING SHALL be ignored (backpressure only); no byte lost or overwritten.
REQ-022 Index SHALL never exceed ARRAY_SIZE-1; no wrap-around within a frame.

Reset
REQ-023 Reset SHALL force state RECEIVING, index 0, buffer 0, out_error 0; outputs after reset: in_ready=1, out_valid=0, out_data=0, out_error=0.
REQ-024 Reset mid-frame or during SENDING SHALL discard partial or pending array without emitting it.

Configuration
REQ-025 Macro ARRAY_LOAD_LAST_CHECK_EN, when defined: in_last on byte k<ARRAY_SIZE-1 SHALL end the frame early, move to SENDING with remaining bytes 0 and out_error=1.
REQ-026 With ARRAY_LOAD_LAST_CHECK_EN defined: byte ARRAY_SIZE-1 accepted without in_last SHALL set out_error=1; with in_last set, out_error=0.
REQ-027 Without ARRAY_LOAD_LAST_CHECK_EN: in_last SHALL be ignored, frames delimited by count only, out_error tied 0.

Structure
REQ-028 State encodings (RECEIVING=0, SENDING=1) SHALL live in the shared array_util package, common with the byte-dump serializer.
REQ-029 ARRAY_SIZE and index-width derivation SHALL be package constant functions shared with the serializer.
REQ-030 No sub-module; single flat module with one next-state combinational block and one registered block.

Verification
REQ-031 Params 2x2x8 (ARRAY_SIZE 4): bytes 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> out_data=0x44332211, out_valid one cycle after 4th byte, out_error=0.
REQ-032 Same params, out_ready=0 for 5 cycles after out_valid -> out_data held, in_ready=0, extra in_valid bytes ignored; release -> in_ready=1 next cycle.
REQ-033 With ARRAY_LOAD_LAST_CHECK_EN: bytes 0xAA,0xBB with in_last on 2nd -> out_data=0x0000BBAA, out_error=1.
REQ-034 With ARRAY_LOAD_LAST_CHECK_EN: 4 bytes, no in_last -> out_error=1; repeat with in_last on 4th -> out_error=0.
REQ-035 Reset asserted after 2 of 4 bytes -> no out_valid; next frame 0x01,0x02,0x03,0x04 -> out_data=0x04030201.
REQ-036 Default params, 48 bytes value=index with random in_valid gaps, 2 frames -> each out_data byte k equals k; loopback through serializer reproduces stream.
